led_matrix_scan_drv: RTL
========================

// Module: led_matrix_scan_drv
// PURPOSE
//  Parametrised row-multiplexed LED matrix driver, successor of the fixed 8x8 byte scanner.
//  Scans ROWS rows of COLS columns from a double-buffered frame; new frames commit only at frame boundary (no tearing).
//  Adds per-row blanking (anti-ghosting), global PWM brightness and selectable pin polarity.
//  Sits between the MCU-facing frame register and the matrix row/column pins.
// PARAMETERS
//  ROWS           8     number of rows (>=2)
//  COLS           8     number of columns (>=1)
//  PRESCALE       1024  clocks per row slot
//  BLANK          16    leading clocks of each slot with all outputs dark (BLANK < PRESCALE)
//  BR_BITS        4     brightness width; (PRESCALE-BLANK) must be a multiple of 2**BR_BITS
//  ROW_ACTIVE_LOW 0     1: row pins are active-low
//  COL_ACTIVE_LOW 0     1: column pins are active-low
// PORTS
//  clock        in   1              single system clock, all logic on posedge
//  reset        in   1              synchronous, active-high
//  data         in   ROWS*COLS      frame; row r = data[r*COLS +: COLS], bit c = column c
//  load         in   1              capture data into shadow buffer this cycle
//  pending      out  1              shadow holds a frame not yet committed
//  oe           in   1              1: scan; 0: outputs dark, scan held at start
//  brightness   in   BR_BITS        global duty, 0 = 1/2**BR_BITS, max = full
//  row          out  ROWS           one-hot row drive (polarity per ROW_ACTIVE_LOW)
//  column       out  COLS           column drive (polarity per COL_ACTIVE_LOW)
//  frame_start  out  1              one-cycle pulse, pins showing slot (r=0,t=0)
// BEHAVIOUR
//  Reset: row/column at inactive level, active=shadow=0, pending=0, r=0, t=0, frame_start=0.
//  Counters: t counts 0..PRESCALE-1 per slot; at t=PRESCALE-1, t->0, r->r+1, wrapping ROWS-1->0.
//  Slot: SLOT=(PRESCALE-BLANK)>>BR_BITS; ON=SLOT*(br+1); br = brightness sampled at t=0.
//   t<BLANK: all dark. t>=BLANK: row bit r active; column=active[r] while (t-BLANK)<ON, else dark.
//  Outputs registered: pins lag internal (r,t) by exactly 1 clock; no combinational path to pins.
//  load: shadow<=data, pending<=1. Commit: active<=shadow, pending<=0, at the cycle r wraps
//   ROWS-1->0 (t=PRESCALE-1), or on any cycle with oe=0.
//  load and commit same cycle: commit takes the OLD shadow; new data captured; pending stays 1.
//  oe=0: r,t forced to 0 next cycle, pins dark next cycle; loads still accepted.
//  oe 0->1: first enabled cycle has r=0,t=0; frame_start pulses on the following cycle.
//  Brightness changes mid-row take effect at next slot start only.
//  reset mid-frame: immediate return to reset state next clock; shadow content discarded.
//  Polarity: dark level is 0 for active-high pins, 1 for active-low, applied at output register.
// STRUCTURE
//  Package led_matrix_pkg: polarity helper (drive(level, active_low)), index width function clog2.
//  Sub-module led_scan_timer: t/r counters, slot_start, frame_wrap strobes, oe hold.
//  Top holds shadow/active buffers, pending, PWM compare and output registers.
// TESTING (ROWS=4, COLS=4, PRESCALE=20, BLANK=4, BR_BITS=2 -> SLOT=4)
//  Reset with oe=1 -> row=0000, column=0000, pending=0 until first scan slot is past blank.
//  load data=16'h8421, oe=1, br=3 -> after wrap, row 0001 col 0001 for 16 clk, row 0010 col 0010 ...
//  br=0 -> column active 4 clocks per slot after 4 blank clocks, dark for remaining 12.
//  load mid-frame -> pending=1 until wrap; old frame shown through row 3, new from row 0.
//  load on wrap cycle -> committed frame = earlier shadow, pending remains 1, new frame next wrap.
//  oe low then high; ROW_ACTIVE_LOW=1 -> pins 1111/col dark; frame_start one clock after oe rise.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// Shared helpers for the LED matrix scanner: index-width calculation and pin polarity mapping.
package led_matrix_pkg;

    // Smallest width able to index n items; never less than 1 bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic drive(input logic level, input logic active_low);
        return level ^ active_low;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Row-slot timer: t counts clocks inside a row slot, r selects the row; both held at zero while oe is low.
module led_scan_timer
    import led_matrix_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int PRESCALE = 1024,
    parameter int RW       = clog2(ROWS),
    parameter int TW       = clog2(PRESCALE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          oe_i,
    output logic [RW-1:0] r_o,
    output logic [TW-1:0] t_o,
    output logic          slot_start_o,
    output logic          frame_wrap_o
);

    localparam logic [TW-1:0] T_LAST = TW'(PRESCALE - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);

    logic [RW-1:0] r_q, r_d;
    logic [TW-1:0] t_q, t_d;

    always_comb begin
        r_d = r_q;
        t_d = t_q + 1'b1;
        if (!oe_i) begin
            r_d = '0;
            t_d = '0;
        end else if (t_q == T_LAST) begin
            t_d = '0;
            r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
            t_q <= '0;
        end else begin
            r_q <= r_d;
            t_q <= t_d;
        end
    end

    assign r_o          = r_q;
    assign t_o          = t_q;
    assign slot_start_o = (t_q == '0);
    assign frame_wrap_o = oe_i && (t_q == T_LAST) && (r_q == R_LAST);

endmodule

// File: rtl/led_matrix_scan_drv.sv
// Row-multiplexed LED matrix driver: double-buffered frame, per-slot blanking, global PWM brightness,
// configurable pin polarity. All pins come straight from registers.
module led_matrix_scan_drv
    import led_matrix_pkg::*;
#(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int PRESCALE       = 1024,
    parameter int BLANK          = 16,
    parameter int BR_BITS        = 4,
    parameter int ROW_ACTIVE_LOW = 0,
    parameter int COL_ACTIVE_LOW = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ROWS*COLS-1:0] data,
    input  logic                 load,
    output logic                 pending,
    input  logic                 oe,
    input  logic [BR_BITS-1:0]   brightness,
    output logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      column,
    output logic                 frame_start
);

    localparam int   RW   = clog2(ROWS);
    localparam int   TW   = clog2(PRESCALE);
    localparam int   CW   = TW + 1;  // one spare bit so ON = PRESCALE-BLANK never overflows
    localparam int   SLOT = (PRESCALE - BLANK) >> BR_BITS;
    localparam int   N    = ROWS * COLS;
    localparam logic RAL  = (ROW_ACTIVE_LOW != 0);
    localparam logic CAL  = (COL_ACTIVE_LOW != 0);

    logic [RW-1:0]      r;
    logic [TW-1:0]      t;
    logic               slot_start, frame_wrap, commit;
    logic [N-1:0]       shadow_q, active_q;
    logic               pending_q;
    logic [BR_BITS-1:0] br_q, br_eff;
    logic [ROWS-1:0]    row_q, row_d;
    logic [COLS-1:0]    col_q, col_d, row_bits;
    logic               fs_q, fs_d;
    logic [CW-1:0]      on_w, off_w;
    logic               lit_row, lit_col;

    led_scan_timer #(.ROWS(ROWS), .PRESCALE(PRESCALE), .RW(RW), .TW(TW)) u_timer (
        .clock        (clock),
        .reset        (reset),
        .oe_i         (oe),
        .r_o          (r),
        .t_o          (t),
        .slot_start_o (slot_start),
        .frame_wrap_o (frame_wrap)
    );

    assign commit = frame_wrap || !oe;

    // A load coinciding with a commit still lands in shadow, so pending stays set.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            br_q      <= '0;
        end else begin
            if (commit) active_q <= shadow_q;
            if (load) begin
                shadow_q  <= data;
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
            if (slot_start) br_q <= brightness;
        end
    end

    // Brightness is frozen per slot; at t=0 the live input is the value being sampled.
    assign br_eff = slot_start ? brightness : br_q;

    always_comb begin
        on_w     = CW'(SLOT * (int'(br_eff) + 1));
        off_w    = CW'(t) - CW'(BLANK);
        lit_row  = oe && (CW'(t) >= CW'(BLANK));
        lit_col  = lit_row && (off_w < on_w);
        row_bits = active_q[int'(r)*COLS +: COLS];
        fs_d     = oe && (r == '0) && (t == '0);
        row_d    = '0;
        col_d    = '0;
        for (int i = 0; i < ROWS; i++) row_d[i] = drive(lit_row && (r == RW'(i)), RAL);
        for (int c = 0; c < COLS; c++) col_d[c] = drive(lit_col && row_bits[c], CAL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q <= {ROWS{RAL}};
            col_q <= {COLS{CAL}};
            fs_q  <= 1'b0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            fs_q  <= fs_d;
        end
    end

    assign pending     = pending_q;
    assign row         = row_q;
    assign column      = col_q;
    assign frame_start = fs_q;

endmodule
